rv32i_data_mem_ctrl: RTL and testbench

- Parametrised, multi-cycle successor to the single-cycle data memory used by the RV32I core.
- Adds a request/response handshake with configurable wait states, byte/half/word stores, sign/zero-extended loads, and error reporting for misaligned or out-of-range accesses.
- Sits between the core's load/store path and on-chip data RAM; the core stalls until rsp_valid.

---
 rtl/rv32i_data_mem_ctrl.sv | 168 ++++++++++++++++
 tb/tb_rv32i_data_mem_ctrl.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/rv32i_data_mem_ctrl.sv
// RV32I data memory controller: req/rsp handshake, programmable wait states,
// sub-word stores, sign/zero-extended loads and fault reporting.
module rv32i_data_mem_ctrl #(
    parameter int DEPTH   = 256,
    parameter int LATENCY = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req,
    input  logic        we,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    input  logic [1:0]  d_size,
    input  logic [2:0]  load_type,
    output logic        req_ready,
    output logic        busy,
    output logic        rsp_valid,
    output logic [31:0] rdata,
    output logic        err
);

    localparam int AW = $clog2(DEPTH);

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_RESP
    } state_t;

    state_t      r_state, w_next;
    logic [3:0]  r_cnt, w_cnt_next;
    logic        r_we;
    logic [31:0] r_addr, r_wdata;
    logic [1:0]  r_size;
    logic [2:0]  r_ltype;
    logic [31:0] r_mem [DEPTH];

    logic          w_accept, w_commit;
    logic          w_we;
    logic [31:0]   w_addr, w_wdata;
    logic [1:0]    w_dsize, w_ld_sz, w_sz;
    logic [2:0]    w_ltype;
    logic          w_oob, w_misal, w_err, w_sext;
    logic [AW-1:0] w_idx;
    logic [31:0]   w_word, w_shift, w_load, w_wd;
    logic [3:0]    w_be;

    assign w_accept = (r_state == S_IDLE) && req;
    // Zero-latency commits on the accept edge, so it works from live inputs.
    assign w_commit = reset && ((LATENCY == 0) ? w_accept
                                : (r_state == S_WAIT && r_cnt == 4'd0));

    assign w_we    = (LATENCY == 0) ? we        : r_we;
    assign w_addr  = (LATENCY == 0) ? addr      : r_addr;
    assign w_wdata = (LATENCY == 0) ? wdata     : r_wdata;
    assign w_dsize = (LATENCY == 0) ? d_size    : r_size;
    assign w_ltype = (LATENCY == 0) ? load_type : r_ltype;

    always_comb begin
        w_next     = r_state;
        w_cnt_next = r_cnt;
        case (r_state)
            S_IDLE: begin
                if (req) begin
                    if (LATENCY == 0) begin
                        w_next = S_RESP;
                    end else begin
                        w_next     = S_WAIT;
                        w_cnt_next = 4'(LATENCY - 1);
                    end
                end
            end
            S_WAIT: begin
                if (r_cnt == 4'd0) w_next = S_RESP;
                else               w_cnt_next = r_cnt - 4'd1;
            end
            S_RESP:  w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    always_comb begin
        w_ld_sz = 2'b11;
        case (w_ltype)
            3'b000, 3'b100: w_ld_sz = 2'b00;
            3'b001, 3'b101: w_ld_sz = 2'b01;
            3'b010:         w_ld_sz = 2'b10;
            default:        w_ld_sz = 2'b11;
        endcase
    end

    assign w_sz    = w_we ? w_dsize : w_ld_sz;
    assign w_sext  = ~w_ltype[2];
    assign w_oob   = (w_addr[31:2] >> AW) != 30'd0;
    assign w_misal = (w_sz == 2'b01 && w_addr[0]) ||
                     (w_sz == 2'b10 && w_addr[1:0] != 2'b00);
    assign w_err   = w_oob || w_misal || (w_sz == 2'b11);
    assign w_idx   = w_addr[AW+1:2];
    assign w_word  = r_mem[w_idx];
    assign w_shift = w_word >> {w_addr[1:0], 3'b000};

    always_comb begin
        w_load = w_word;
        w_be   = 4'b1111;
        w_wd   = w_wdata;
        case (w_sz)
            2'b00: begin
                w_load = w_sext ? {{24{w_shift[7]}}, w_shift[7:0]}
                                : {24'd0, w_shift[7:0]};
                w_be   = 4'b0001 << w_addr[1:0];
                w_wd   = {4{w_wdata[7:0]}};
            end
            2'b01: begin
                w_load = w_sext ? {{16{w_shift[15]}}, w_shift[15:0]}
                                : {16'd0, w_shift[15:0]};
                w_be   = w_addr[1] ? 4'b1100 : 4'b0011;
                w_wd   = {2{w_wdata[15:0]}};
            end
            default: begin
                w_load = w_word;
                w_be   = 4'b1111;
                w_wd   = w_wdata;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= S_IDLE;
            r_cnt   <= 4'd0;
            r_we    <= 1'b0;
            r_addr  <= 32'd0;
            r_wdata <= 32'd0;
            r_size  <= 2'b00;
            r_ltype <= 3'b000;
            rdata   <= 32'd0;
            err     <= 1'b0;
        end else begin
            r_state <= w_next;
            r_cnt   <= w_cnt_next;
            if (w_accept) begin
                r_we    <= we;
                r_addr  <= addr;
                r_wdata <= wdata;
                r_size  <= d_size;
                r_ltype <= load_type;
            end
            if (w_commit) begin
                err   <= w_err;
                rdata <= (w_err || w_we) ? 32'd0 : w_load;
            end
        end
    end

    // RAM contents deliberately survive reset.
    always_ff @(posedge clk) begin
        if (w_commit && w_we && !w_err) begin
            for (int i = 0; i < 4; i++) begin
                if (w_be[i]) r_mem[w_idx][8*i +: 8] <= w_wd[8*i +: 8];
            end
        end
    end

    assign req_ready = (r_state == S_IDLE);
    assign busy      = (r_state != S_IDLE);
    assign rsp_valid = (r_state == S_RESP);

endmodule

// File: tb/tb_rv32i_data_mem_ctrl.sv
// Scoreboard bench for rv32i_data_mem_ctrl: LATENCY=2 main instance and a
// LATENCY=0 instance for back-to-back throughput.
module tb_rv32i_data_mem_ctrl;

    localparam int LAT = 2;
    localparam int DEP = 256;

    logic        clk = 1'b0;
    logic        reset;
    logic        req, we;
    logic [31:0] addr, wdata;
    logic [1:0]  d_size;
    logic [2:0]  load_type;
    logic        req_ready, busy, rsp_valid, err;
    logic [31:0] rdata;

    logic        req0, we0;
    logic [31:0] addr0, wdata0;
    logic        req_ready0, busy0, rsp_valid0, err0;
    logic [31:0] rdata0;

    typedef struct {
        logic [31:0] rd;
        logic        er;
        int          due;
    } exp_t;

    exp_t sb[$];
    exp_t m_e;
    int   cyc = 0;
    int   n_tests = 0;
    int   n_fail = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    rv32i_data_mem_ctrl #(.DEPTH(DEP), .LATENCY(LAT)) u_dut (
        .clk(clk), .reset(reset), .req(req), .we(we), .addr(addr),
        .wdata(wdata), .d_size(d_size), .load_type(load_type),
        .req_ready(req_ready), .busy(busy), .rsp_valid(rsp_valid),
        .rdata(rdata), .err(err)
    );

    rv32i_data_mem_ctrl #(.DEPTH(16), .LATENCY(0)) u_dut0 (
        .clk(clk), .reset(reset), .req(req0), .we(we0), .addr(addr0),
        .wdata(wdata0), .d_size(2'b10), .load_type(3'b010),
        .req_ready(req_ready0), .busy(busy0), .rsp_valid(rsp_valid0),
        .rdata(rdata0), .err(err0)
    );

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    always @(negedge clk) begin
        if (reset && rsp_valid) begin
            if (sb.size() == 0) begin
                chk("spurious_rsp", 32'd1, 32'd0);
            end else begin
                m_e = sb.pop_front();
                chk("rdata", rdata, m_e.rd);
                chk("err", {31'd0, err}, {31'd0, m_e.er});
                chk("rsp_cycle", 32'(cyc), 32'(m_e.due));
            end
        end
    end

    task automatic access(input logic w, input logic [31:0] a,
                          input logic [31:0] wd, input logic [1:0] sz,
                          input logic [2:0] lt, input logic [31:0] er,
                          input logic ee);
        bit ok;
        ok = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (req_ready) begin
                ok = 1;
                break;
            end
        end
        if (!ok) begin
            chk("ready_timeout", 32'd0, 32'd1);
            return;
        end
        we = w; addr = a; wdata = wd; d_size = sz; load_type = lt;
        req = 1'b1;
        sb.push_back('{er, ee, cyc + 1 + LAT});
        ok = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (rsp_valid) begin
                ok = 1;
                break;
            end
        end
        if (!ok) begin
            chk("rsp_timeout", 32'd0, 32'd1);
            sb.delete();
        end
        req = 1'b0;
    endtask

    task automatic store(input logic [31:0] a, input logic [31:0] wd,
                         input logic [1:0] sz, input logic ee);
        access(1'b1, a, wd, sz, 3'b010, 32'd0, ee);
    endtask

    task automatic load(input logic [31:0] a, input logic [2:0] lt,
                        input logic [31:0] er, input logic ee);
        access(1'b0, a, 32'hFFFF_FFFF, 2'b10, lt, er, ee);
    endtask

    task automatic chk_reset_outs(input string tag);
        chk({tag, "_rsp_valid"}, {31'd0, rsp_valid}, 32'd0);
        chk({tag, "_busy"}, {31'd0, busy}, 32'd0);
        chk({tag, "_req_ready"}, {31'd0, req_ready}, 32'd1);
        chk({tag, "_rdata"}, rdata, 32'd0);
        chk({tag, "_err"}, {31'd0, err}, 32'd0);
    endtask

    initial begin : main
        bit          ok;
        int          prev;
        logic [31:0] x_rd;
        logic        x_er;
        reset = 1'b0;
        req = 0; we = 0; addr = 0; wdata = 0; d_size = 2'b10;
        load_type = 3'b010;
        req0 = 0; we0 = 0; addr0 = 0; wdata0 = 0;
        repeat (3) @(negedge clk);
        chk_reset_outs("reset");
        reset = 1'b1;

        store(32'h10, 32'hDEAD_BEEF, 2'b10, 1'b0);
        load(32'h10, 3'b010, 32'hDEAD_BEEF, 1'b0);

        store(32'h20, 32'h1122_3344, 2'b10, 1'b0);
        store(32'h23, 32'h0000_0080, 2'b00, 1'b0);
        load(32'h20, 3'b010, 32'h8022_3344, 1'b0);
        load(32'h23, 3'b000, 32'hFFFF_FF80, 1'b0);
        load(32'h23, 3'b100, 32'h0000_0080, 1'b0);

        store(32'h21, 32'h0000_AAAA, 2'b01, 1'b1);
        load(32'h20, 3'b010, 32'h8022_3344, 1'b0);
        load(32'h22, 3'b010, 32'h0, 1'b1);
        load(32'h20, 3'b011, 32'h0, 1'b1);

        store(32'h22, 32'h1234_BEEF, 2'b01, 1'b0);
        load(32'h20, 3'b010, 32'hBEEF_3344, 1'b0);
        load(32'h22, 3'b001, 32'hFFFF_BEEF, 1'b0);
        load(32'h22, 3'b101, 32'h0000_BEEF, 1'b0);
        load(32'h20, 3'b001, 32'h0000_3344, 1'b0);
        load(32'h21, 3'b100, 32'h0000_0033, 1'b0);

        store(32'h0, 32'h0BAD_F00D, 2'b10, 1'b0);
        store(32'h400, 32'hFFFF_FFFF, 2'b10, 1'b1);
        load(32'h400, 3'b010, 32'h0, 1'b1);
        load(32'h0, 3'b010, 32'h0BAD_F00D, 1'b0);
        store(32'h0, 32'h5555_5555, 2'b11, 1'b1);
        access(1'b0, 32'h0, 32'h0, 2'b11, 3'b010, 32'h0BAD_F00D, 1'b0);

        store(32'h40, 32'h1234_5678, 2'b10, 1'b0);
        load(32'h40, 3'b010, 32'h1234_5678, 1'b0);
        @(negedge clk);
        we = 1'b1; addr = 32'h40; wdata = 32'h5555_AAAA; d_size = 2'b10;
        req = 1'b1;
        @(negedge clk);
        chk("wait_busy", {31'd0, busy}, 32'd1);
        reset = 1'b0;
        #1;
        chk_reset_outs("rst_in_wait");
        req = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        repeat (6) @(negedge clk);
        load(32'h40, 3'b010, 32'h1234_5678, 1'b0);

        @(negedge clk);
        prev = 0;
        req0 = 1'b1;
        for (int i = 0; i < 10; i++) begin
            x_er = 1'b0;
            if (i < 4) begin
                we0 = 1'b1; addr0 = 32'(4 * i);
                wdata0 = 32'hC0DE_0000 + 32'(i);
                x_rd = 32'd0;
            end else if (i < 8) begin
                we0 = 1'b0; addr0 = 32'(4 * (i - 4));
                x_rd = 32'hC0DE_0000 + 32'(i - 4);
            end else if (i == 8) begin
                we0 = 1'b0; addr0 = 32'd64;
                x_rd = 32'd0; x_er = 1'b1;
            end else begin
                we0 = 1'b0; addr0 = 32'd0;
                x_rd = 32'hC0DE_0000;
            end
            ok = 0;
            for (int j = 0; j < 10; j++) begin
                @(negedge clk);
                if (rsp_valid0) begin
                    ok = 1;
                    break;
                end
            end
            if (!ok) begin
                chk("l0_timeout", 32'd0, 32'd1);
            end else begin
                chk("l0_rdata", rdata0, x_rd);
                chk("l0_err", {31'd0, err0}, {31'd0, x_er});
                chk("l0_ready_in_resp", {31'd0, req_ready0}, 32'd0);
                if (i > 0) chk("l0_gap", 32'(cyc - prev), 32'd2);
                prev = cyc;
            end
        end
        req0 = 1'b0;

        repeat (3) @(negedge clk);
        chk("sb_empty", 32'(sb.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
